// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and size-decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

  function automatic logic size_is_byte(input logic [2:0] s);
    return (s == LDST_B) || (s == LDST_BU);
  endfunction

  function automatic logic size_is_half(input logic [2:0] s);
    return (s == LDST_H) || (s == LDST_HU);
  endfunction

  // Codes 2, 3, 6 and 7 all behave as a full word.
  function automatic logic size_is_word(input logic [2:0] s);
    return !size_is_byte(s) && !size_is_half(s);
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the LSU. Signal suffixes are relative to the LSU;
// the slave modport is the LSU, the master modport is the core/memory environment.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  logic        misalign_o;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i,
    output misalign_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i,
    input  misalign_o
  );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane logic: store byte enables + replicated write data, and
// sign/zero-extended load formatting from the raw memory word.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_size_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] st_wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  input  logic [2:0]  ld_size_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_fmt_o
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] raw_b;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign raw_b   = ld_raw_i;
  assign ld_byte = raw_b[ld_lane_i];
  assign ld_half = ld_lane_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];

  always_comb begin
    be_o = 4'b1111;
    wd_o = st_wd_i;
    if (size_is_byte(st_size_i)) begin
      be_o = 4'b0001 << st_lane_i;
      wd_o = {4{st_wd_i[7:0]}};
    end else if (size_is_half(st_size_i)) begin
      be_o = st_lane_i[1] ? 4'b1100 : 4'b0011;
      wd_o = {2{st_wd_i[15:0]}};
    end
  end

  always_comb begin
    case (ld_size_i)
      LDST_B:  ld_fmt_o = {{24{ld_byte[7]}}, ld_byte};
      LDST_BU: ld_fmt_o = {24'h0, ld_byte};
      LDST_H:  ld_fmt_o = {{16{ld_half[15]}}, ld_half};
      LDST_HU: ld_fmt_o = {16'h0, ld_half};
      default: ld_fmt_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the core data port and a word-addressed memory with ready handshake.
// Optional misaligned-access detection is enabled by defining LSU_MISALIGN_CHECK_EN.
module riscv_lsu
  import lsu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  riscv_lsu_if.slave bus
);
  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] ld_fmt;
  logic [1:0]  lane;
  logic        misalign;
  logic        active;

  assign lane = bus.core_addr_i[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = bus.core_req_i &
                    ((size_is_half(bus.core_size_i) & lane[0]) |
                     (size_is_word(bus.core_size_i) & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Store path uses the live request; load formatting uses the request captured on issue.
  lsu_data_align u_align (
    .st_size_i (bus.core_size_i),
    .st_lane_i (lane),
    .st_wd_i   (bus.core_wd_i),
    .be_o      (bus.mem_be_o),
    .wd_o      (bus.mem_wd_o),
    .ld_size_i (size_q),
    .ld_lane_i (lane_q),
    .ld_raw_i  (bus.mem_rd_i),
    .ld_fmt_o  (ld_fmt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= LDST_W;
      lane_q  <= 2'b00;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    lane_d  = lane_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        // Ready in this cycle is ignored: every access spends at least one cycle in BUSY.
        if (bus.core_req_i && !misalign) begin
          state_d = BUSY;
          we_d    = bus.core_we_i;
          size_d  = bus.core_size_i;
          lane_d  = lane;
        end
      end
      BUSY: begin
        if (bus.mem_ready_i) begin
          state_d = DONE;
          if (!we_q) rd_d = ld_fmt;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active           = !rst_i && bus.core_req_i && (state_q != DONE) && !misalign;
    bus.mem_req_o    = active;
    bus.mem_we_o     = active && bus.core_we_i;
    bus.core_stall_o = active;
    bus.misalign_o   = !rst_i && misalign;
  end

  assign bus.core_rd_o  = rd_q;
  assign bus.mem_addr_o = bus.core_addr_i;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: vector table of accesses through a latency-controlled
// memory model, plus reset-in-flight and misalignment sequences.
module tb_riscv_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_lsu_if bus ();

  riscv_lsu u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] raw;
    int          lat;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int          stalls;
    int          wes;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[17];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd  = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] raw, input int lat,
                              input logic [3:0] be, input logic [31:0] mwd, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.raw = raw;
    v.lat = lat; v.be = be; v.mwd = mwd; v.rd = rd;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the DONE edge so accesses run back to back.
  task automatic run(input vec_t v);
    exp_t e;
    int   stalls;
    int   wes;
    bit   done;
    e.rd     = v.we ? last_rd : v.rd;
    e.stalls = ((v.lat == 0) ? 1 : v.lat) + 1;
    e.wes    = v.we ? e.stalls : 0;
    if (!v.we) last_rd = v.rd;
    sb.push_back(e);

    bus.core_req_i  = 1'b1;
    bus.core_we_i   = v.we;
    bus.core_size_i = v.size;
    bus.core_addr_i = v.addr;
    bus.core_wd_i   = v.wd;
    bus.mem_rd_i    = v.raw;
    bus.mem_ready_i = (v.lat == 0);
    #1;
    chk("mem_be", {28'h0, bus.mem_be_o}, {28'h0, v.be});
    chk("mem_wd", bus.mem_wd_o, v.mwd);
    chk("mem_addr", bus.mem_addr_o, v.addr);
    chk("misalign_aligned", {31'h0, bus.misalign_o}, 32'h0);

    stalls = 0;
    wes    = 0;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
        bus.mem_ready_i = (k >= v.lat);
        #1;
      end
      if (bus.core_stall_o) begin
        stalls++;
        if (bus.mem_we_o) wes++;
      end else begin
        done = 1'b1;
      end
    end

    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: stall still 1 after 40 cycles, addr %h", v.addr);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("stall_cycles", stalls, e.stalls);
      chk("mem_we_cycles", wes, e.wes);
      chk("mem_req_done", {31'h0, bus.mem_req_o}, 32'h0);
      chk("core_rd", bus.core_rd_o, e.rd);
    end
    @(posedge clk);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, LDST_W,  32'h100, 32'hDEADBEEF, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(1'b1, LDST_B,  32'h103, 32'h000000A5, 32'h0,        1, 4'b1000, 32'hA5A5A5A5, 32'h0);
    tbl[2]  = mk(1'b1, LDST_H,  32'h102, 32'h00001234, 32'h0,        2, 4'b1100, 32'h12341234, 32'h0);
    tbl[3]  = mk(1'b0, LDST_B,  32'h101, 32'h0,        32'h80FF7F01, 1, 4'b0010, 32'h0, 32'h0000007F);
    tbl[4]  = mk(1'b0, LDST_B,  32'h103, 32'h0,        32'h80FF7F01, 1, 4'b1000, 32'h0, 32'hFFFFFF80);
    tbl[5]  = mk(1'b0, LDST_BU, 32'h103, 32'h0,        32'h80FF7F01, 1, 4'b1000, 32'h0, 32'h00000080);
    tbl[6]  = mk(1'b0, LDST_H,  32'h102, 32'h0,        32'h80FF7F01, 1, 4'b1100, 32'h0, 32'hFFFF80FF);
    tbl[7]  = mk(1'b0, LDST_HU, 32'h102, 32'h0,        32'h80FF7F01, 1, 4'b1100, 32'h0, 32'h000080FF);
    tbl[8]  = mk(1'b0, LDST_W,  32'h100, 32'h0,        32'h80FF7F01, 4, 4'b1111, 32'h0, 32'h80FF7F01);
    tbl[9]  = mk(1'b0, LDST_W,  32'h104, 32'h0,        32'h12345678, 1, 4'b1111, 32'h0, 32'h12345678);
    tbl[10] = mk(1'b0, LDST_H,  32'h100, 32'h0,        32'h7FFF8001, 0, 4'b0011, 32'h0, 32'hFFFF8001);
    tbl[11] = mk(1'b0, LDST_BU, 32'h100, 32'h0,        32'h000000FE, 2, 4'b0001, 32'h0, 32'h000000FE);
    tbl[12] = mk(1'b1, LDST_B,  32'h101, 32'h123456C3, 32'h0,        1, 4'b0010, 32'hC3C3C3C3, 32'h0);
    tbl[13] = mk(1'b0, 3'd3,    32'h108, 32'h0,        32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'hCAFEF00D);
    tbl[14] = mk(1'b1, 3'd7,    32'h10C, 32'h01020304, 32'h0,        3, 4'b1111, 32'h01020304, 32'h0);
    tbl[15] = mk(1'b0, LDST_H,  32'h100, 32'h0,        32'h12347FFF, 1, 4'b0011, 32'h0, 32'h00007FFF);
    tbl[16] = mk(1'b0, 3'd6,    32'h110, 32'h0,        32'h0BADF00D, 1, 4'b1111, 32'h0, 32'h0BADF00D);

    // Reset held with a live (misaligned-looking) request and a stray ready.
    rst             = 1'b1;
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b1;
    bus.core_size_i = LDST_W;
    bus.core_addr_i = 32'h102;
    bus.core_wd_i   = 32'h0;
    bus.mem_rd_i    = 32'hFFFFFFFF;
    bus.mem_ready_i = 1'b1;
    #1;
    chk("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_we_o}, 32'h0);
    chk("rst_stall", {31'h0, bus.core_stall_o}, 32'h0);
    chk("rst_misalign", {31'h0, bus.misalign_o}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_core_rd", bus.core_rd_o, 32'h0);
    rst             = 1'b0;
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) run(tbl[i]);

`ifdef LSU_MISALIGN_CHECK_EN
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = LDST_W;
    bus.core_addr_i = 32'h102;
    bus.mem_rd_i    = 32'h11111111;
    bus.mem_ready_i = 1'b1;
    #1;
    chk("mis_lw_flag", {31'h0, bus.misalign_o}, 32'h1);
    chk("mis_lw_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("mis_lw_stall", {31'h0, bus.core_stall_o}, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("mis_stays_idle", {31'h0, bus.core_stall_o}, 32'h0);
    chk("mis_rd_hold", bus.core_rd_o, last_rd);
    bus.core_size_i = LDST_H;
    bus.core_addr_i = 32'h101;
    #1;
    chk("mis_lh_flag", {31'h0, bus.misalign_o}, 32'h1);
    bus.core_size_i = LDST_B;
    #1;
    chk("mis_lb_ok", {31'h0, bus.misalign_o}, 32'h0);
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
`else
    run(mk(1'b0, LDST_W, 32'h102, 32'h0, 32'h11111111, 1, 4'b1111, 32'h0, 32'h11111111));
`endif

    // Reset while an access is waiting in BUSY.
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = LDST_W;
    bus.core_addr_i = 32'h200;
    bus.mem_rd_i    = 32'h55555555;
    bus.mem_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("busy_stall", {31'h0, bus.core_stall_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("midrst_stall", {31'h0, bus.core_stall_o}, 32'h0);
    chk("midrst_rd", bus.core_rd_o, 32'h0);
    bus.mem_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst             = 1'b0;
    bus.core_req_i  = 1'b0;
    bus.mem_rd_i    = 32'h99999999;
    @(posedge clk);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("late_ready_rd", bus.core_rd_o, 32'h0);
    chk("late_ready_stall", {31'h0, bus.core_stall_o}, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    run(mk(1'b0, LDST_BU, 32'h201, 32'h0, 32'h0000AB00, 1, 4'b0010, 32'h0, 32'h000000AB));
    bus.core_req_i = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit placed between the riscv_core data port and the data memory / peripheral bus.
- Core side: consumes the core's mem_req/mem_we/mem_size/mem_addr/mem_wd and returns the formatted read data and a stall.
- Memory side: drives a word-addressed memory with byte enables and a ready handshake.
- Converts sub-word accesses into byte-lane writes and sign/zero-extended reads. Holds the core stalled until the memory completes.

Parameters:
- None. Data and address widths are fixed at 32.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- core_req_i  in  1  core requests a memory access this cycle
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  access size, funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  formatted load data (registered)
- core_stall_o  out  1  core must hold pc and the request
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte-lane enables
- mem_addr_o  out  32  byte address, passed through unchanged
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  raw memory read word, valid when mem_ready_i is 1
- mem_ready_i  in  1  memory completes the current request this cycle
- misalign_o  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset values (rst_i high, asynchronous):
  - state = IDLE, core_rd_o = 0.
  - mem_req_o, mem_we_o, core_stall_o and misalign_o are forced to 0 while rst_i is high.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if core_req_i, go to BUSY and capture the request (we, size, addr[1:0]). A request with mem_ready_i already high in this cycle still goes to BUSY; it is not completed early.
  - BUSY: on mem_ready_i, latch the formatted mem_rd_i into core_rd_o (loads only) and go to DONE. Otherwise stay in BUSY.
  - DONE: unconditionally return to IDLE.
- Output equations:
  - mem_req_o = core_req_i & (state != DONE)
  - mem_we_o = mem_req_o & core_we_i
  - core_stall_o = core_req_i & (state != DONE)
- Timing:
  - Minimum access with 1-cycle ready: 3 cycles, pattern stall 1, 1, 0.
  - The core advances on the DONE edge. A back-to-back request re-enters IDLE and issues on the following cycle.
- The core holds core_* stable while stalled. The LSU uses the live inputs and does not re-sample them.
- Store byte enables (a = addr[1:0]):
  - B: be = 0001 << a
  - H: be = 0011 << (a[1]*2)
  - W: be = 1111
- Store data:
  - B: byte replicated 4 times
  - H: half replicated 2 times
  - W: passed through
- Load formatting: select byte at lane a, or half at lane a[1]. Sign-extend for 0/1, zero-extend for 4/5, W passes through.
- Unused size codes: 3/6/7 behave as W.
- mem_be_o is driven for loads too (same rule); memory may ignore it.
- core_rd_o is unchanged by stores and holds its value between loads.
- Reset mid-access: immediate return to IDLE, request dropped, no completion reported. A late mem_ready_i is ignored in IDLE.
- mem_ready_i in IDLE or DONE is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - misalign_o = core_req_i & ((H/HU & a[0]) | (W & a != 0)), combinational.
  - When misalign_o = 1: no mem_req_o, core_stall_o = 0, FSM stays IDLE. The core routes this to its trap logic.
- Undefined:
  - misalign_o is tied to 0.
  - Low address bits beyond lane selection are ignored (H uses a[1] only, W ignores a).

Decomposition:
- Package lsu_pkg holds:
  - localparams LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5
  - typedef enum logic [1:0] lsu_state_t {IDLE, BUSY, DONE}
- One sub-module is natural: lsu_data_align. It is purely combinational and produces byte enables, replicated write data and the formatted load word. The FSM stays in riscv_lsu.

Test Plan:
- SW 0xDEADBEEF to 0x100, ready after 1 cycle -> be=1111, wd=0xDEADBEEF, stall pattern 1,1,0, mem_we_o=1 for 2 cycles.
- SB 0x000000A5 to 0x103 -> be=1000, wd=0xA5A5A5A5. SH 0x1234 to 0x102 -> be=1100, wd=0x12341234.
- Memory returns 0x80FF7F01:
  - LB @0x101 -> 0x0000007F
  - LB @0x103 -> 0xFFFFFF80
  - LBU @0x103 -> 0x00000080
  - LH @0x102 -> 0xFFFF80FF
  - LHU @0x102 -> 0x000080FF
- mem_ready_i delayed 4 cycles -> stall held 5 cycles, then 0 for exactly one cycle. Two consecutive loads complete correctly.
- rst_i asserted while in BUSY -> mem_req_o and core_stall_o drop the same cycle. After release, a ready pulse with no request does not change core_rd_o.
- With LSU_MISALIGN_CHECK_EN defined, LW @0x102 -> misalign_o=1, mem_req_o=0, stall=0. Without the macro -> normal access, be=1111, misalign_o=0.
